// File: rtl/bu_req_arb.sv
// Bus-unit request arbiter: grants one cache channel at a time, muxes its request to the bus
// unit and routes responses back to the owner. Define BU_ARB_TIMEOUT_EN to add a BUSY watchdog.
module bu_req_arb #(
  parameter int NCH   = 2,
  parameter int PAW   = 64,
  parameter int DW    = 64,
  parameter int CW    = 11,
  parameter int RR_EN = 1,
  parameter int TMO   = 1023,
  localparam int IW   = $clog2(NCH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH-1:0]     ch_req,
  input  logic [2*NCH-1:0]   ch_op,
  input  logic [4*NCH-1:0]   ch_size,
  input  logic [PAW*NCH-1:0] ch_pa,
  input  logic [DW*NCH-1:0]  ch_wt_data,
  output logic [DW-1:0]      ch_line_data,
  output logic [CW-1:0]      ch_addr_count,
  output logic [NCH-1:0]     ch_line_write,
  output logic [NCH-1:0]     ch_entry_write,
  output logic [NCH-1:0]     ch_trans_rdy,
  output logic [NCH-1:0]     ch_bus_error,
  output logic               read_req,
  output logic               read_line_req,
  output logic               write_through_req,
  output logic               write_line_req,
  output logic [3:0]         size,
  output logic [PAW-1:0]     pa,
  output logic [DW-1:0]      wt_data,
  input  logic [DW-1:0]      line_data,
  input  logic [CW-1:0]      addr_count,
  input  logic               line_write,
  input  logic               cache_entry_write,
  input  logic               trans_rdy,
  input  logic               bus_error,
  output logic               gnt_vld,
  output logic [IW-1:0]      gnt_id
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] win_id;
  logic [IW-1:0] gnt_inc;
  logic          any_req;
  logic          found;
  logic          done;
  logic          tmo_hit;
  logic          gate;
  logic [1:0]    op;
  int            cand;

  // Winner search; with RR_EN=0 the scan always starts at channel 0.
  always_comb begin
    win_id = '0;
    found  = 1'b0;
    cand   = 0;
    for (int k = 0; k < NCH; k++) begin
      cand = (RR_EN != 0) ? int'(rr_ptr) + k : k;
      if (cand >= NCH) cand = cand - NCH;
      if (!found && ch_req[cand]) begin
        found  = 1'b1;
        win_id = IW'(cand);
      end
    end
  end

  assign any_req = |ch_req;
  assign gnt_inc = (gnt_id == IW'(NCH - 1)) ? '0 : gnt_id + 1'b1;
  assign done    = trans_rdy | bus_error | tmo_hit;

`ifdef BU_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TMO + 1);
  logic [TW-1:0] wdog;

  // Cleared throughout IDLE so it starts at zero on the first BUSY cycle.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE) wdog <= '0;
    else                      wdog <= wdog + 1'b1;
  end

  assign tmo_hit = (state == BUSY) && (wdog == TW'(TMO));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      gnt_id <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) gnt_id <= win_id;
      if (state == BUSY && done)    rr_ptr <= gnt_inc;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = BUSY;
      BUSY:    if (done)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt_vld           = (state == BUSY);
    op                = ch_op[int'(gnt_id)*2 +: 2];
    gate              = gnt_vld & ch_req[gnt_id];
    read_req          = gate & (op == 2'b00);
    read_line_req     = gate & (op == 2'b01);
    write_through_req = gate & (op == 2'b10);
    write_line_req    = gate & (op == 2'b11);
    size              = ch_size[int'(gnt_id)*4 +: 4];
    pa                = ch_pa[int'(gnt_id)*PAW +: PAW];
    wt_data           = ch_wt_data[int'(gnt_id)*DW +: DW];
    ch_line_data      = line_data;
    ch_addr_count     = addr_count;
    ch_line_write     = '0;
    ch_entry_write    = '0;
    ch_trans_rdy      = '0;
    ch_bus_error      = '0;
    if (gnt_vld) begin
      ch_line_write[gnt_id]  = line_write;
      ch_entry_write[gnt_id] = cache_entry_write;
      ch_trans_rdy[gnt_id]   = trans_rdy;
      ch_bus_error[gnt_id]   = bus_error | tmo_hit;
    end
  end

endmodule

// File: tb/tb_bu_req_arb.sv
// Self-checking bench for bu_req_arb: a round-robin and a fixed-priority instance share stimulus
// and are compared every cycle against a per-instance owner/pointer reference model.
module tb_bu_req_arb;
  localparam int NCH = 4;
  localparam int PAW = 64;
  localparam int DW  = 64;
  localparam int CW  = 11;
  localparam int TMO = 16;
`ifdef BU_ARB_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NCH-1:0]     ch_req = '0;
  logic [2*NCH-1:0]   ch_op = '0;
  logic [4*NCH-1:0]   ch_size = '0;
  logic [PAW*NCH-1:0] ch_pa = '0;
  logic [DW*NCH-1:0]  ch_wt_data = '0;
  logic [DW-1:0]      line_data = '0;
  logic [CW-1:0]      addr_count = '0;
  logic               line_write = 1'b0;
  logic               cache_entry_write = 1'b0;
  logic               trans_rdy = 1'b0;
  logic               bus_error = 1'b0;

  logic [DW-1:0]  o_ldata [2];
  logic [CW-1:0]  o_acnt  [2];
  logic [NCH-1:0] o_lw    [2];
  logic [NCH-1:0] o_ew    [2];
  logic [NCH-1:0] o_tr    [2];
  logic [NCH-1:0] o_be    [2];
  logic           o_rd    [2];
  logic           o_rl    [2];
  logic           o_wt    [2];
  logic           o_wl    [2];
  logic [3:0]     o_size  [2];
  logic [PAW-1:0] o_pa    [2];
  logic [DW-1:0]  o_wd    [2];
  logic           o_gv    [2];
  logic [1:0]     o_gid   [2];

  int checks = 0;
  int errors = 0;
  // Reference model per instance: owner = -1 when idle.
  int owner   [2];
  int last_id [2];
  int ptr     [2];
  int age     [2];

  always #5 clk = ~clk;

  bu_req_arb #(.NCH(NCH), .PAW(PAW), .DW(DW), .CW(CW), .RR_EN(1), .TMO(TMO)) dut_rr (
    .clk(clk), .rst(rst), .ch_req(ch_req), .ch_op(ch_op), .ch_size(ch_size), .ch_pa(ch_pa),
    .ch_wt_data(ch_wt_data), .ch_line_data(o_ldata[0]), .ch_addr_count(o_acnt[0]),
    .ch_line_write(o_lw[0]), .ch_entry_write(o_ew[0]), .ch_trans_rdy(o_tr[0]),
    .ch_bus_error(o_be[0]), .read_req(o_rd[0]), .read_line_req(o_rl[0]),
    .write_through_req(o_wt[0]), .write_line_req(o_wl[0]), .size(o_size[0]), .pa(o_pa[0]),
    .wt_data(o_wd[0]), .line_data(line_data), .addr_count(addr_count), .line_write(line_write),
    .cache_entry_write(cache_entry_write), .trans_rdy(trans_rdy), .bus_error(bus_error),
    .gnt_vld(o_gv[0]), .gnt_id(o_gid[0]));

  bu_req_arb #(.NCH(NCH), .PAW(PAW), .DW(DW), .CW(CW), .RR_EN(0), .TMO(TMO)) dut_fp (
    .clk(clk), .rst(rst), .ch_req(ch_req), .ch_op(ch_op), .ch_size(ch_size), .ch_pa(ch_pa),
    .ch_wt_data(ch_wt_data), .ch_line_data(o_ldata[1]), .ch_addr_count(o_acnt[1]),
    .ch_line_write(o_lw[1]), .ch_entry_write(o_ew[1]), .ch_trans_rdy(o_tr[1]),
    .ch_bus_error(o_be[1]), .read_req(o_rd[1]), .read_line_req(o_rl[1]),
    .write_through_req(o_wt[1]), .write_line_req(o_wl[1]), .size(o_size[1]), .pa(o_pa[1]),
    .wt_data(o_wd[1]), .line_data(line_data), .addr_count(addr_count), .line_write(line_write),
    .cache_entry_write(cache_entry_write), .trans_rdy(trans_rdy), .bus_error(bus_error),
    .gnt_vld(o_gv[1]), .gnt_id(o_gid[1]));

  task automatic chk(input string tag, input int d, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      bit         busy;
      int         ow;
      logic [1:0] op;
      bit         g;
      bit         tmo;
      logic [3:0] onehot;
      busy   = owner[d] >= 0;
      ow     = busy ? owner[d] : 0;
      op     = ch_op[ow*2 +: 2];
      g      = busy && ch_req[ow];
      tmo    = TO && busy && (age[d] == TMO);
      onehot = busy ? 4'(1 << ow) : 4'b0;
      chk("gnt_vld", d, 64'(o_gv[d]), 64'(busy));
      chk("gnt_id", d, 64'(o_gid[d]), 64'(last_id[d]));
      chk("read_req", d, 64'(o_rd[d]), 64'(g && op == 2'd0));
      chk("read_line_req", d, 64'(o_rl[d]), 64'(g && op == 2'd1));
      chk("write_through_req", d, 64'(o_wt[d]), 64'(g && op == 2'd2));
      chk("write_line_req", d, 64'(o_wl[d]), 64'(g && op == 2'd3));
      if (busy) begin
        chk("size", d, 64'(o_size[d]), 64'(ch_size[ow*4 +: 4]));
        chk("pa", d, o_pa[d], ch_pa[ow*PAW +: PAW]);
        chk("wt_data", d, o_wd[d], ch_wt_data[ow*DW +: DW]);
      end
      chk("ch_line_write", d, 64'(o_lw[d]), 64'(line_write ? onehot : 4'b0));
      chk("ch_entry_write", d, 64'(o_ew[d]), 64'(cache_entry_write ? onehot : 4'b0));
      chk("ch_trans_rdy", d, 64'(o_tr[d]), 64'(trans_rdy ? onehot : 4'b0));
      chk("ch_bus_error", d, 64'(o_be[d]), 64'((bus_error || tmo) ? onehot : 4'b0));
      chk("ch_line_data", d, o_ldata[d], line_data);
      chk("ch_addr_count", d, 64'(o_acnt[d]), 64'(addr_count));
    end
  endtask

  task automatic update_model();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        owner[d] = -1; last_id[d] = 0; ptr[d] = 0; age[d] = 0;
      end else if (owner[d] < 0) begin
        if (ch_req != 0) begin
          int w;
          w = -1;
          for (int k = 0; k < NCH; k++) begin
            int c;
            c = (d == 0) ? (ptr[d] + k) % NCH : k;
            if (w < 0 && ch_req[c]) w = c;
          end
          owner[d] = w; last_id[d] = w; age[d] = 0;
        end
      end else if (trans_rdy || bus_error || (TO && age[d] == TMO)) begin
        ptr[d]   = (owner[d] + 1) % NCH;
        owner[d] = -1;
      end else begin
        age[d]++;
      end
    end
  endtask

  task automatic cycle();
    #1;
    check_all();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic rand_payload();
    for (int i = 0; i < (PAW*NCH)/32; i++) ch_pa[i*32 +: 32] = $urandom();
    for (int i = 0; i < (DW*NCH)/32; i++) ch_wt_data[i*32 +: 32] = $urandom();
    ch_size = 16'($urandom());
  endtask

  task automatic rand_step();
    ch_req            = ch_req ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15));
    ch_op             = 8'($urandom());
    rand_payload();
    line_data         = {$urandom(), $urandom()};
    addr_count        = 11'($urandom());
    line_write        = ($urandom_range(0, 2) == 0);
    cache_entry_write = ($urandom_range(0, 2) == 0);
    trans_rdy         = ($urandom_range(0, 5) == 0);
    bus_error         = ($urandom_range(0, 11) == 0);
    rst               = ($urandom_range(0, 63) == 0);
  endtask

  initial begin
    int exp_rr [5];
    int lw1;
    int lw0;
    int seen;
    exp_rr = '{0, 1, 2, 3, 0};
    lw1 = 0;
    lw0 = 0;
    seen = -1;
    for (int d = 0; d < 2; d++) begin
      owner[d] = -1; last_id[d] = 0; ptr[d] = 0; age[d] = 0;
    end

    // Reset
    @(posedge clk);
    update_model();
    #1;
    cycle();
    rst = 1'b0;

    // Two channels request together from reset: ch0 (read_line) wins, then ch1
    rand_payload();
    ch_req = 4'b0011;
    ch_op  = 8'b0000_1001;
    cycle();
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("first_gnt_id", d, 64'(o_gid[d]), 64'd0);
      chk("first_read_line", d, 64'(o_rl[d]), 64'd1);
      chk("first_pa", d, o_pa[d], ch_pa[PAW-1:0]);
    end
    trans_rdy = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) chk("ch0_trans_rdy", d, 64'(o_tr[d]), 64'b0001);
    cycle();
    trans_rdy = 1'b0;
    ch_req    = 4'b0010;
    #1;
    for (int d = 0; d < 2; d++) chk("idle_gap", d, 64'(o_gv[d]), 64'd0);
    cycle();
    #1;
    for (int d = 0; d < 2; d++) chk("second_gnt_id", d, 64'(o_gid[d]), 64'd1);

    // ch1 write_through owner: line_write routed only to ch1, then bus_error
    for (int i = 0; i < 8; i++) begin
      line_write = 1'b1;
      #1;
      lw1 += int'(o_lw[0][1]);
      lw0 += int'(o_lw[0][0]);
      cycle();
      line_write = 1'b0;
      cycle();
    end
    chk("ch1_line_write_pulses", 0, 64'(lw1), 64'd8);
    chk("ch0_line_write_pulses", 0, 64'(lw0), 64'd0);
    bus_error = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) chk("ch1_bus_error", d, 64'(o_be[d]), 64'b0010);
    cycle();
    bus_error = 1'b0;
    ch_req    = '0;
    cycle();

    // All four requesting continuously: grant order after a reset
    rst = 1'b1;
    cycle();
    rst    = 1'b0;
    ch_req = 4'hF;
    ch_op  = 8'($urandom());
    for (int i = 0; i < 5; i++) begin
      cycle();
      #1;
      chk("rr_order", 0, 64'(o_gid[0]), 64'(exp_rr[i]));
      chk("fp_order", 1, 64'(o_gid[1]), 64'd0);
      trans_rdy = 1'b1;
      cycle();
      trans_rdy = 1'b0;
    end

    // Reset in the third BUSY cycle aborts the grant
    ch_req = 4'b0100;
    ch_op  = 8'b0;
    cycle();
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst    = 1'b0;
    ch_req = '0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("abort_gnt_vld", d, 64'(o_gv[d]), 64'd0);
      chk("abort_read_req", d, 64'(o_rd[d]), 64'd0);
      chk("abort_trans_rdy", d, 64'(o_tr[d]), 64'd0);
    end
    cycle();

    // Responses while IDLE are dropped
    trans_rdy = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) chk("idle_trans_rdy", d, 64'(o_tr[d]), 64'd0);
    cycle();
    cycle();
    trans_rdy = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) chk("idle_stays", d, 64'(o_gv[d]), 64'd0);

`ifdef BU_ARB_TIMEOUT_EN
    // Watchdog fires TMO cycles after BUSY entry with no response
    ch_req = 4'b0001;
    ch_op  = 8'b0000_0011;
    cycle();
    for (int k = 0; k < TMO + 4; k++) begin
      #1;
      if (o_be[0][0] === 1'b1) begin
        seen = k;
        cycle();
        break;
      end
      cycle();
    end
    chk("tmo_cycle", 0, 64'(seen), 64'(TMO));
    ch_req = '0;
    #1;
    chk("tmo_idle", 0, 64'(o_gv[0]), 64'd0);
    cycle();
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      rand_step();
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bu_req_arb.md
BU_REQ_ARB -- requirements
Module: bu_req_arb

Interface
REQ-001 Parameter NCH, default 2: number of cache requester channels, 2..8; channel 0 is lowest index.
REQ-002 Parameter PAW, default 64: physical address width.
REQ-003 Parameter DW, default 64: data width.
REQ-004 Parameter CW, default 11: addr_count width.
REQ-005 Parameter RR_EN, default 1: 1 selects round-robin arbitration, 0 selects fixed priority (lowest index wins).
REQ-006 Parameter TMO, default 1023: watchdog limit in cycles, used only with BU_ARB_TIMEOUT_EN.
REQ-007 The block SHALL have one clock and a synchronous, active-high reset: clk  in  1  clock; rst  in  1  reset.
REQ-008 ch_req  in  NCH  per-channel request, held until that channel's ch_trans_rdy or ch_bus_error.
REQ-009 ch_op  in  2*NCH  per-channel op: 00 read, 01 read_line, 10 write_through, 11 write_line.
REQ-010 ch_size / ch_pa / ch_wt_data  in  4*NCH / PAW*NCH / DW*NCH  packed per-channel size, address, write data.
REQ-011 ch_line_data / ch_addr_count  out  DW / CW  broadcast of line_data / addr_count.
REQ-012 ch_line_write, ch_entry_write, ch_trans_rdy, ch_bus_error  out  NCH each  per-channel routed responses.
REQ-013 read_req, read_line_req, write_through_req, write_line_req  out  1 each  requests to the bus unit.
REQ-014 size / pa / wt_data  out  4 / PAW / DW  muxed request payload.
REQ-015 line_data, addr_count, line_write, cache_entry_write, trans_rdy, bus_error  in  DW, CW, 1, 1, 1, 1  bus unit responses.
REQ-016 gnt_vld / gnt_id  out  1 / clog2(NCH)  current owner status.

Function
REQ-017 FSM states: IDLE, BUSY.
REQ-018 IDLE: if any ch_req is set, the winner SHALL be registered into gnt_id and the FSM SHALL enter BUSY on the next edge; with no request, the FSM SHALL stay in IDLE.
REQ-019 Round-robin: the search SHALL start at rr_ptr and wrap from NCH-1 to 0. After every completion, rr_ptr SHALL become (gnt_id+1) mod NCH.
REQ-020 With RR_EN=0, the lowest set index SHALL win, and rr_ptr is unused.
REQ-021 BUSY: the op decode of ch_op[gnt_id] SHALL drive exactly one bus request, gated by ch_req[gnt_id]. size, pa and wt_data SHALL come from channel gnt_id.
REQ-022 All bus requests SHALL be 0 when gnt_vld=0; no ungated pass-through is allowed.
REQ-023 Response routing SHALL be combinational: ch_X[gnt_id] = gnt_vld & X, for X in line_write, entry_write, trans_rdy, bus_error. Non-owner bits SHALL be 0.
REQ-024 trans_rdy or bus_error in BUSY SHALL return the FSM to IDLE on the next edge, giving at least one IDLE cycle between grants.
REQ-025 A requester dropping ch_req mid-BUSY SHALL NOT release the grant; only trans_rdy, bus_error or the watchdog releases it.
REQ-026 Requests arriving during BUSY SHALL wait; they are never lost or reordered.
REQ-027 trans_rdy and bus_error in the same cycle: both SHALL be routed to the owner, with a single release.
REQ-028 Responses while IDLE SHALL be ignored and not routed.

Reset
REQ-029 On rst: FSM in IDLE, gnt_vld=0, gnt_id=0, rr_ptr=0, watchdog=0. Every request and every per-channel response output SHALL be 0 from the first post-reset cycle.
REQ-030 Reset asserted mid-BUSY SHALL abort the grant with no response pulse to the owner.

Configuration
REQ-031 Macro BU_ARB_TIMEOUT_EN defined: a counter SHALL increment each BUSY cycle and clear on entering BUSY. On reaching TMO without trans_rdy or bus_error, it SHALL pulse ch_bus_error[gnt_id] for one cycle and return to IDLE with the rr_ptr update.
REQ-032 Macro BU_ARB_TIMEOUT_EN undefined: no counter SHALL exist, and BUSY SHALL persist until a bus response.

Verification
REQ-033 NCH=2: ch_req=2'b11 in the same cycle from reset, ch0 op=01 -> grant ch0; read_line_req=1, pa=ch0 pa. trans_rdy -> ch_trans_rdy=2'b01; next grant is ch1 after one IDLE cycle.
REQ-034 NCH=4, RR_EN=1: all four channels request continuously -> grant order 0,1,2,3,0. With RR_EN=0 -> grant order 0,0,0.
REQ-035 ch1 owner, op=10, line_write pulses 8 times -> ch_line_write[1] pulses 8 times and ch_line_write[0] stays 0. bus_error -> ch_bus_error=2'b10.
REQ-036 rst asserted in the 3rd BUSY cycle -> next cycle gnt_vld=0, all bus requests 0, no ch_trans_rdy pulse.
REQ-037 BU_ARB_TIMEOUT_EN, TMO=16, no bus response -> ch_bus_error[owner] pulses exactly 16 cycles after BUSY entry, then FSM enters IDLE.
REQ-038 trans_rdy pulsed while IDLE -> all ch_trans_rdy remain 0 and the FSM stays in IDLE.
